// File: rtl/spi_ram_slave_burst.sv
// SPI slave with an internal DEPTH x DATA_WIDTH RAM, sampled on the system clock.
// Frame protocol: SS_n low opens a frame. The first two MOSI bits are the command,
// followed by the payload, MSB first. SS_n sampled high ends the frame on that edge.
// There is no separate valid/ready: each rising edge with SS_n low transfers one bit
// in, and MISO carries one bit out per edge while read data is being shifted.
module spi_ram_slave_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       frame_err,
  output logic [2:0] o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int MAXW  = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW    = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_ADDR = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_LOAD = 3'd5,
    S_RD_DATA = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_cmd_hi;
  logic [CW-1:0]           r_cnt;
  logic [MAXW-2:0]         r_stage;
  logic [MAXW-1:0]         w_stage_next;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_frame_err;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic w_addr_last;
  logic w_word_last;
  logic w_wr_addr_ld;
  logic w_rd_addr_ld;
  logic w_mem_we;
  logic w_shift_ld;
  logic w_shift_en;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_abort;

  // Staging word including the bit being sampled on this edge.
  assign w_stage_next = {r_stage, MOSI};
  assign w_addr_last  = (r_cnt == CW'(ADDR_WIDTH - 1));
  assign w_word_last  = (r_cnt == CW'(DATA_WIDTH - 1));
  assign frame_err    = r_frame_err;
  assign o_dbg_state  = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; SS_n high always closes the frame.
  always_comb begin
    w_next = r_state;
    if (SS_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_CMD;
        S_CMD: begin
          case ({r_cmd_hi, MOSI})
            2'b00:   w_next = S_WR_ADDR;
            2'b01:   w_next = S_WR_DATA;
            2'b10:   w_next = S_RD_ADDR;
            default: w_next = S_RD_LOAD;
          endcase
        end
        S_WR_ADDR, S_RD_ADDR: if (w_addr_last) w_next = S_DONE;
        S_WR_DATA, S_RD_DATA: if (w_word_last && (AUTO_INC == 0)) w_next = S_DONE;
        S_RD_LOAD: w_next = S_RD_DATA;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Output and datapath-control decode for the current state and inputs.
  always_comb begin
    w_wr_addr_ld = 1'b0;
    w_rd_addr_ld = 1'b0;
    w_mem_we     = 1'b0;
    w_shift_ld   = 1'b0;
    w_shift_en   = 1'b0;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_abort      = 1'b0;
    if (SS_n) begin
      w_cnt_clr = 1'b1;
      case (r_state)
        S_CMD:                           w_abort = 1'b1;
        S_WR_ADDR, S_RD_ADDR, S_WR_DATA: w_abort = (r_cnt != '0);
        default:                         w_abort = 1'b0;
      endcase
    end else begin
      case (r_state)
        S_WR_ADDR: begin
          w_cnt_en     = 1'b1;
          w_wr_addr_ld = w_addr_last;
        end
        S_RD_ADDR: begin
          w_cnt_en     = 1'b1;
          w_rd_addr_ld = w_addr_last;
        end
        S_WR_DATA: begin
          if (w_word_last) begin
            w_mem_we  = 1'b1;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        S_RD_LOAD: begin
          w_shift_ld = 1'b1;
          w_cnt_clr  = 1'b1;
        end
        S_RD_DATA: begin
          if (w_word_last) begin
            w_cnt_clr = 1'b1;
            if (AUTO_INC != 0) w_shift_ld = 1'b1;
            else               w_shift_en = 1'b1;
          end else begin
            w_cnt_en   = 1'b1;
            w_shift_en = 1'b1;
          end
        end
        default: w_cnt_clr = 1'b1;
      endcase
    end
    MISO = (r_state == S_RD_DATA) ? r_shift[DATA_WIDTH-1] : 1'b0;
  end

  // Counters, staging, address registers, read shifter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_hi    <= 1'b0;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      r_stage     <= w_stage_next[MAXW-2:0];
      if (r_state == S_IDLE) r_cmd_hi <= MOSI;

      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= r_cnt + CW'(1);

      if (w_wr_addr_ld)                       r_wr_addr <= w_stage_next[ADDR_WIDTH-1:0];
      else if (w_mem_we && (AUTO_INC != 0))   r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);

      if (w_rd_addr_ld)                       r_rd_addr <= w_stage_next[ADDR_WIDTH-1:0];
      else if (w_shift_ld && (AUTO_INC != 0)) r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);

      if (w_shift_ld)      r_shift <= r_mem[r_rd_addr];
      else if (w_shift_en) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Memory write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_addr] <= w_stage_next[DATA_WIDTH-1:0];
  end

endmodule
